// File: rtl/reg_pkg.sv
// Register file read-side shared types: read request and writeback forwarding port.
package reg_pkg;

    localparam int WORD_SIZE     = 32;
    localparam int NUM_PHYS_REGS = 64;
    localparam int PHYS_IDX_W    = $clog2(NUM_PHYS_REGS);

    typedef struct packed {
        logic                       valid;
        logic [1:0][PHYS_IDX_W-1:0] idx;
        logic [1:0]                 use_mask;
    } RfReadReq;

    typedef struct packed {
        logic                  en;
        logic [PHYS_IDX_W-1:0] index;
        logic [WORD_SIZE-1:0]  data;
    } RfFwdPort;

    function automatic logic [1:0] req_cost(input logic [1:0] use_mask);
        return {1'b0, use_mask[0]} + {1'b0, use_mask[1]};
    endfunction

endpackage

// File: rtl/rr_port_allocator.sv
// Combinational round-robin scan that hands register file read ports to requesters in order.
module rr_port_allocator
    import reg_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int NUM_READ_PORTS = 4,
    localparam int REQ_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  RfReadReq [NUM_REQ-1:0]                   req,
    input  logic [REQ_W-1:0]                         rr_ptr,
    output logic [NUM_REQ-1:0]                       grant,
    output logic [NUM_READ_PORTS-1:0]                port_en,
    output logic [NUM_READ_PORTS-1:0][REQ_W-1:0]     port_owner,
    output logic [NUM_READ_PORTS-1:0]                port_opnd,
    output logic [REQ_W-1:0]                         last_grant,
    output logic                                     any_grant
);

    localparam int CNT_W = $clog2(NUM_READ_PORTS + 1);

    always_comb begin
        logic [REQ_W:0]   r_ext;
        logic [REQ_W-1:0] r;
        RfReadReq         cur;
        logic [1:0]       cost;
        logic [CNT_W-1:0] remaining;
        logic [CNT_W-1:0] next_port;
        logic             stop;

        grant      = '0;
        port_en    = '0;
        port_owner = '0;
        port_opnd  = '0;
        last_grant = rr_ptr;
        any_grant  = 1'b0;
        r_ext      = '0;
        r          = '0;
        cur        = '0;
        cost       = '0;
        remaining  = CNT_W'(NUM_READ_PORTS);
        next_port  = '0;
        stop       = 1'b0;

        for (int s = 0; s < NUM_REQ; s++) begin
            r_ext = {1'b0, rr_ptr} + (REQ_W+1)'(s);
            if (r_ext >= (REQ_W+1)'(NUM_REQ))
                r_ext = r_ext - (REQ_W+1)'(NUM_REQ);
            r = r_ext[REQ_W-1:0];

            cur = '0;
            for (int j = 0; j < NUM_REQ; j++)
                if (REQ_W'(j) == r) cur = req[j];
            cost = req_cost(cur.use_mask);

            // The first valid requester that does not fit ends the scan: no skipping past it.
            if (!stop && cur.valid) begin
                if (CNT_W'(cost) <= remaining) begin
                    for (int j = 0; j < NUM_REQ; j++)
                        if (REQ_W'(j) == r) grant[j] = 1'b1;
                    any_grant  = 1'b1;
                    last_grant = r;
                    for (int o = 0; o < 2; o++) begin
                        if (cur.use_mask[o]) begin
                            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                                if (CNT_W'(p) == next_port) begin
                                    port_en[p]    = 1'b1;
                                    port_owner[p] = r;
                                    port_opnd[p]  = 1'(o);
                                end
                            end
                            next_port = next_port + CNT_W'(1);
                        end
                    end
                    remaining = remaining - CNT_W'(cost);
                end else begin
                    stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares register file read ports among issue requesters, forwards writeback data, registers operands.
module regfile_read_arbiter #(
    parameter int WORD_SIZE      = reg_pkg::WORD_SIZE,
    parameter int NUM_PHYS_REGS  = reg_pkg::NUM_PHYS_REGS,
    parameter int NUM_REQ        = 4,
    parameter int NUM_READ_PORTS = 4,
    parameter int NUM_FWD        = 2,
    localparam int IDX_W         = $clog2(NUM_PHYS_REGS),
    localparam int REQ_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          flush,
    input  reg_pkg::RfReadReq [NUM_REQ-1:0]               req,
    output logic [NUM_REQ-1:0]                            req_ready,
    output logic [NUM_READ_PORTS-1:0]                     rf_read_en,
    output logic [NUM_READ_PORTS-1:0][IDX_W-1:0]          rf_read_index,
    input  logic [NUM_READ_PORTS-1:0][WORD_SIZE-1:0]      rf_read_data,
    input  reg_pkg::RfFwdPort [NUM_FWD-1:0]               fwd,
    output logic [NUM_REQ-1:0]                            resp_valid,
    output logic [NUM_REQ-1:0][1:0][WORD_SIZE-1:0]        resp_data
);

    logic [REQ_W-1:0]                            rr_ptr;
    logic [NUM_REQ-1:0]                          grant;
    logic [NUM_READ_PORTS-1:0]                   port_en;
    logic [NUM_READ_PORTS-1:0][REQ_W-1:0]        port_owner;
    logic [NUM_READ_PORTS-1:0]                   port_opnd;
    logic [REQ_W-1:0]                            last_grant;
    logic                                        any_grant;
    logic                                        active;
    logic [NUM_READ_PORTS-1:0][WORD_SIZE-1:0]    port_data;
    logic [NUM_REQ-1:0][1:0][WORD_SIZE-1:0]      opnd_data;
    logic [NUM_REQ-1:0]                          resp_valid_p1;
    logic [NUM_REQ-1:0][1:0][WORD_SIZE-1:0]      resp_data_p1;

    rr_port_allocator #(
        .NUM_REQ        (NUM_REQ),
        .NUM_READ_PORTS (NUM_READ_PORTS)
    ) u_alloc (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .grant      (grant),
        .port_en    (port_en),
        .port_owner (port_owner),
        .port_opnd  (port_opnd),
        .last_grant (last_grant),
        .any_grant  (any_grant)
    );

    assign active     = !rst && !flush;
    assign req_ready  = active ? grant : '0;
    assign rf_read_en = active ? port_en : '0;

    // Stage p0: port index drive, forwarding (lowest fwd port wins), operand steering.
    always_comb begin
        logic [IDX_W-1:0] sel_idx;
        sel_idx       = '0;
        rf_read_index = '0;
        port_data     = '0;
        opnd_data     = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            sel_idx = '0;
            for (int j = 0; j < NUM_REQ; j++)
                if (port_owner[p] == REQ_W'(j)) sel_idx = req[j].idx[port_opnd[p]];
            rf_read_index[p] = rf_read_en[p] ? sel_idx : '0;

            port_data[p] = rf_read_data[p];
            for (int k = NUM_FWD - 1; k >= 0; k--)
                if (fwd[k].en && fwd[k].index == rf_read_index[p])
                    port_data[p] = fwd[k].data;
        end
        for (int j = 0; j < NUM_REQ; j++)
            for (int o = 0; o < 2; o++)
                for (int p = 0; p < NUM_READ_PORTS; p++)
                    if (rf_read_en[p] && port_owner[p] == REQ_W'(j) && port_opnd[p] == 1'(o))
                        opnd_data[j][o] = port_data[p];
    end

    // Stage p1: registered response and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            resp_valid_p1 <= '0;
            resp_data_p1  <= '0;
        end else begin
            resp_valid_p1 <= req_ready;
            resp_data_p1  <= opnd_data;
            if (active && any_grant)
                rr_ptr <= (last_grant == REQ_W'(NUM_REQ - 1)) ? '0 : last_grant + REQ_W'(1);
        end
    end

    assign resp_valid = resp_valid_p1;
    assign resp_data  = resp_data_p1;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a behavioural register file behind the read ports.
module tb_regfile_read_arbiter;

    logic                         clk;
    logic                         rst;
    logic                         flush;
    reg_pkg::RfReadReq [3:0]      req;
    logic [3:0]                   req_ready;
    logic [3:0]                   rf_read_en;
    logic [3:0][5:0]              rf_read_index;
    logic [3:0][31:0]             rf_read_data;
    reg_pkg::RfFwdPort [1:0]      fwd;
    logic [3:0]                   resp_valid;
    logic [3:0][1:0][31:0]        resp_data;

    logic [31:0] mem [64];
    int total = 0;
    int bad   = 0;

    regfile_read_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .req           (req),
        .req_ready     (req_ready),
        .rf_read_en    (rf_read_en),
        .rf_read_index (rf_read_index),
        .rf_read_data  (rf_read_data),
        .fwd           (fwd),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rf_read_data = '0;
        for (int p = 0; p < 4; p++) rf_read_data[p] = mem[rf_read_index[p]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int j, input logic v, input logic [5:0] i0,
                           input logic [5:0] i1, input logic [1:0] u);
        req[j].valid    = v;
        req[j].idx[0]   = i0;
        req[j].idx[1]   = i1;
        req[j].use_mask = u;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
        mem[17] = 32'h11;
        rst = 1'b1; flush = 1'b0; req = '0; fwd = '0;

        // Reset holds grants and port enables low even with every requester valid.
        for (int j = 0; j < 4; j++) set_req(j, 1'b1, 6'(4*j+1), 6'(4*j+2), 2'b11);
        tick(); tick();
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_en", 64'(rf_read_en), 64'h0);
        chk("rst_index", 64'(rf_read_index), 64'h0);
        req = '0; rst = 1'b0;
        tick();
        chk("post_rst_valid", 64'(resp_valid), 64'h0);
        chk("post_rst_data0", 64'(resp_data[0]), 64'h0);
        chk("post_rst_rr", 64'(dut.rr_ptr), 64'h0);

        // Full load: two requesters per cycle, alternating halves.
        for (int j = 0; j < 4; j++) set_req(j, 1'b1, 6'(4*j+1), 6'(4*j+2), 2'b11);
        #1;
        chk("full_c0_ready", 64'(req_ready), 64'h3);
        chk("full_c0_en", 64'(rf_read_en), 64'hF);
        chk("full_c0_index", 64'(rf_read_index), 64'({6'd6, 6'd5, 6'd2, 6'd1}));
        tick();
        chk("full_c0_rr", 64'(dut.rr_ptr), 64'h2);
        chk("full_c0_rvalid", 64'(resp_valid), 64'h3);
        chk("full_r0_op0", 64'(resp_data[0][0]), 64'(mem[1]));
        chk("full_r0_op1", 64'(resp_data[0][1]), 64'(mem[2]));
        chk("full_r1_op0", 64'(resp_data[1][0]), 64'(mem[5]));
        chk("full_r1_op1", 64'(resp_data[1][1]), 64'(mem[6]));
        chk("full_c1_ready", 64'(req_ready), 64'hC);
        chk("full_c1_index", 64'(rf_read_index), 64'({6'd14, 6'd13, 6'd10, 6'd9}));
        tick();
        chk("full_c1_rr", 64'(dut.rr_ptr), 64'h0);
        chk("full_c1_rvalid", 64'(resp_valid), 64'hC);
        chk("full_r2_op0", 64'(resp_data[2][0]), 64'(mem[9]));
        chk("full_r3_op1", 64'(resp_data[3][1]), 64'(mem[14]));
        req = '0;
        tick();

        // Head-of-line: req2 does not fit in the single remaining port, scan stops there.
        set_req(0, 1'b1, 6'd20, 6'd21, 2'b11);
        set_req(1, 1'b1, 6'd22, 6'd23, 2'b01);
        set_req(2, 1'b1, 6'd24, 6'd25, 2'b11);
        #1;
        chk("hol_ready", 64'(req_ready), 64'h3);
        chk("hol_en", 64'(rf_read_en), 64'h7);
        chk("hol_index", 64'(rf_read_index), 64'({6'd0, 6'd22, 6'd21, 6'd20}));
        tick();
        chk("hol_rr", 64'(dut.rr_ptr), 64'h2);
        chk("hol_rvalid", 64'(resp_valid), 64'h3);
        chk("hol_r1_op0", 64'(resp_data[1][0]), 64'(mem[22]));
        chk("hol_r1_op1_unused", 64'(resp_data[1][1]), 64'h0);
        req = '0;

        // Forwarding: lowest matching fwd port wins, then fwd1 alone, then the register file.
        set_req(0, 1'b1, 6'd17, 6'd0, 2'b01);
        fwd[0] = '{en: 1'b1, index: 6'd17, data: 32'hAA};
        fwd[1] = '{en: 1'b1, index: 6'd17, data: 32'hBB};
        #1;
        chk("fwd_ready", 64'(req_ready), 64'h1);
        chk("fwd_index0", 64'(rf_read_index[0]), 64'd17);
        tick();
        chk("fwd_prio", 64'(resp_data[0][0]), 64'hAA);
        chk("fwd_rr", 64'(dut.rr_ptr), 64'h1);
        fwd[0].en = 1'b0;
        tick();
        chk("fwd_second", 64'(resp_data[0][0]), 64'hBB);
        fwd = '0;
        tick();
        chk("fwd_none", 64'(resp_data[0][0]), 64'h11);
        req = '0;

        // Cost-0 request: granted with no port, zero operands.
        set_req(3, 1'b1, 6'd30, 6'd31, 2'b00);
        #1;
        chk("c0_ready", 64'(req_ready), 64'h8);
        chk("c0_en", 64'(rf_read_en), 64'h0);
        tick();
        chk("c0_rvalid", 64'(resp_valid), 64'h8);
        chk("c0_data", 64'(resp_data[3]), 64'h0);
        chk("c0_rr", 64'(dut.rr_ptr), 64'h0);
        req = '0;

        // Flush in the grant cycle kills the grant; flush one cycle later does not.
        set_req(0, 1'b1, 6'd3, 6'd0, 2'b01);
        flush = 1'b1;
        #1;
        chk("fl_ready", 64'(req_ready), 64'h0);
        chk("fl_en", 64'(rf_read_en), 64'h0);
        tick();
        chk("fl_rvalid", 64'(resp_valid), 64'h0);
        chk("fl_rr_hold", 64'(dut.rr_ptr), 64'h0);
        flush = 1'b0;
        #1;
        chk("fl_regrant", 64'(req_ready), 64'h1);
        tick();
        req = '0; flush = 1'b1;
        #1;
        chk("fl_late_rvalid", 64'(resp_valid), 64'h1);
        chk("fl_late_data", 64'(resp_data[0][0]), 64'(mem[3]));
        chk("fl_late_en", 64'(rf_read_en), 64'h0);
        tick();
        flush = 1'b0;
        chk("fl_after_rvalid", 64'(resp_valid), 64'h0);
        chk("fl_after_rr", 64'(dut.rr_ptr), 64'h1);

        // Reset mid-operation drops the would-be response and clears the pointer.
        set_req(1, 1'b1, 6'd7, 6'd8, 2'b11);
        rst = 1'b1;
        #1;
        chk("mrst_ready", 64'(req_ready), 64'h0);
        tick();
        chk("mrst_rvalid", 64'(resp_valid), 64'h0);
        chk("mrst_rr", 64'(dut.rr_ptr), 64'h0);
        rst = 1'b0; req = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
